// File: rtl/mem_stage_pkg.sv
// rtl/mem_stage_pkg.sv - shared widths, aluop encodings and FSM states for the MEM stage
package mem_stage_pkg;

  localparam int REG_BUS_W      = 32;
  localparam int MEM_ADDR_BUS_W = 32;
  localparam int ALU_OP_BUS_W   = 8;

  localparam logic [ALU_OP_BUS_W-1:0] EXE_NOP_OP = 8'b0000_0000;
  localparam logic [ALU_OP_BUS_W-1:0] EXE_ADD_OP = 8'b0010_0000;
  localparam logic [ALU_OP_BUS_W-1:0] EXE_LB_OP  = 8'b1110_0000;
  localparam logic [ALU_OP_BUS_W-1:0] EXE_LH_OP  = 8'b1110_0001;
  localparam logic [ALU_OP_BUS_W-1:0] EXE_LW_OP  = 8'b1110_0011;
  localparam logic [ALU_OP_BUS_W-1:0] EXE_LBU_OP = 8'b1110_0100;
  localparam logic [ALU_OP_BUS_W-1:0] EXE_LHU_OP = 8'b1110_0101;
  localparam logic [ALU_OP_BUS_W-1:0] EXE_SB_OP  = 8'b1110_1000;
  localparam logic [ALU_OP_BUS_W-1:0] EXE_SH_OP  = 8'b1110_1001;
  localparam logic [ALU_OP_BUS_W-1:0] EXE_SW_OP  = 8'b1110_1011;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_DONE = 2'd2
  } mem_state_e;

  function automatic logic is_load_op(input logic [ALU_OP_BUS_W-1:0] op);
    return (op == EXE_LB_OP) || (op == EXE_LBU_OP) || (op == EXE_LH_OP) ||
           (op == EXE_LHU_OP) || (op == EXE_LW_OP);
  endfunction

  function automatic logic is_store_op(input logic [ALU_OP_BUS_W-1:0] op);
    return (op == EXE_SB_OP) || (op == EXE_SH_OP) || (op == EXE_SW_OP);
  endfunction

  function automatic logic is_misaligned(input logic [ALU_OP_BUS_W-1:0] op,
                                         input logic [1:0] addr_lo);
    logic half_op;
    logic word_op;
    half_op = (op == EXE_LH_OP) || (op == EXE_LHU_OP) || (op == EXE_SH_OP);
    word_op = (op == EXE_LW_OP) || (op == EXE_SW_OP);
    return (half_op && addr_lo[0]) || (word_op && (addr_lo != 2'b00));
  endfunction

endpackage

// File: rtl/mem_lane_align.sv
// rtl/mem_lane_align.sv - byte-enable/store-lane generation and load extraction
module mem_lane_align
  import mem_stage_pkg::*;
(
  input  logic [ALU_OP_BUS_W-1:0] aluop,
  input  logic [1:0]              addr_lo,
  input  logic [REG_BUS_W-1:0]    store_data,
  input  logic [REG_BUS_W-1:0]    load_word,
  output logic [3:0]              be,
  output logic [REG_BUS_W-1:0]    wdata,
  output logic [REG_BUS_W-1:0]    load_data
);

  logic [7:0]  lane_b;
  logic [15:0] lane_h;

  always_comb begin
    be = 4'b0000;
    unique case (aluop)
      EXE_LB_OP, EXE_LBU_OP, EXE_SB_OP: be = 4'b0001 << addr_lo;
      EXE_LH_OP, EXE_LHU_OP, EXE_SH_OP: be = addr_lo[1] ? 4'b1100 : 4'b0011;
      EXE_LW_OP, EXE_SW_OP:             be = 4'b1111;
      default:                          be = 4'b0000;
    endcase
  end

  // Stores replicate the datum so whichever lane is enabled carries it.
  always_comb begin
    wdata = store_data;
    unique case (aluop)
      EXE_SB_OP: wdata = {4{store_data[7:0]}};
      EXE_SH_OP: wdata = {2{store_data[15:0]}};
      default:   wdata = store_data;
    endcase
  end

  always_comb begin
    lane_b    = load_word[{addr_lo, 3'b000} +: 8];
    lane_h    = addr_lo[1] ? load_word[31:16] : load_word[15:0];
    load_data = load_word;
    unique case (aluop)
      EXE_LB_OP:  load_data = {{24{lane_b[7]}}, lane_b};
      EXE_LBU_OP: load_data = {24'b0, lane_b};
      EXE_LH_OP:  load_data = {{16{lane_h[15]}}, lane_h};
      EXE_LHU_OP: load_data = {16'b0, lane_h};
      default:    load_data = load_word;
    endcase
  end

endmodule

// File: rtl/mem_stage.sv
// rtl/mem_stage.sv - MEM pipeline stage: load/store sequencing over a req/ack data port
module mem_stage
  import mem_stage_pkg::*;
#(
  parameter int ADDR_W = MEM_ADDR_BUS_W,
  parameter int DATA_W = REG_BUS_W
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [4:0]              mem_reg_waddr,
  input  logic                    mem_we,
  input  logic [DATA_W-1:0]       mem_reg_wdata,
  input  logic [ADDR_W-1:0]       mem_mem_addr,
  input  logic [ALU_OP_BUS_W-1:0] mem_aluop,
  input  logic [DATA_W-1:0]       mem_rt_data,
  input  logic                    hold,
  output logic                    dmem_req,
  output logic                    dmem_wr,
  output logic [ADDR_W-1:0]       dmem_addr,
  output logic [3:0]              dmem_be,
  output logic [DATA_W-1:0]       dmem_wdata,
  input  logic                    dmem_ack,
  input  logic [DATA_W-1:0]       dmem_rdata,
  output logic [4:0]              wb_reg_waddr,
  output logic                    wb_we,
  output logic [DATA_W-1:0]       wb_reg_wdata,
  output logic                    stall_req,
  output logic                    misalign
);

  mem_state_e        state, state_nxt;
  logic [DATA_W-1:0] rdata_q;
  logic [DATA_W-1:0] load_data;
  logic              is_load, is_store, is_mem, bad_align;
  logic              capture;
  logic              req_c, stall_c, we_c, mis_c;
  logic [DATA_W-1:0] wdata_c;

  assign is_load   = is_load_op(mem_aluop);
  assign is_store  = is_store_op(mem_aluop);
  assign is_mem    = is_load || is_store;
  assign bad_align = is_misaligned(mem_aluop, mem_mem_addr[1:0]);

  // Address/lanes follow EX/MEM directly; the stall keeps them stable through WAIT.
  mem_lane_align u_lane_align (
    .aluop      (mem_aluop),
    .addr_lo    (mem_mem_addr[1:0]),
    .store_data (mem_rt_data),
    .load_word  (rdata_q),
    .be         (dmem_be),
    .wdata      (dmem_wdata),
    .load_data  (load_data)
  );

  assign dmem_wr   = is_store;
  assign dmem_addr = {mem_mem_addr[ADDR_W-1:2], 2'b00};

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= ST_IDLE;
      rdata_q <= '0;
    end else begin
      state <= state_nxt;
      if (capture) rdata_q <= dmem_rdata;
    end
  end

  always_comb begin
    state_nxt = state;
    capture   = 1'b0;
    req_c     = 1'b0;
    stall_c   = 1'b0;
    mis_c     = 1'b0;
    we_c      = mem_we;
    wdata_c   = mem_reg_wdata;
    unique case (state)
      ST_IDLE: begin
        if (is_mem) begin
          we_c = 1'b0;
          if (bad_align) begin
            mis_c = 1'b1;
          end else begin
            req_c   = 1'b1;
            stall_c = 1'b1;
            if (dmem_ack) begin
              capture   = 1'b1;
              state_nxt = ST_DONE;
            end else begin
              state_nxt = ST_WAIT;
            end
          end
        end
      end
      ST_WAIT: begin
        req_c   = 1'b1;
        stall_c = 1'b1;
        we_c    = 1'b0;
        if (dmem_ack) begin
          capture   = 1'b1;
          state_nxt = ST_DONE;
        end
      end
      ST_DONE: begin
        we_c    = is_load ? mem_we : 1'b0;
        wdata_c = is_load ? load_data : mem_reg_wdata;
        if (!hold) state_nxt = ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  assign dmem_req     = req_c && !rst;
  assign stall_req    = stall_c && !rst;
  assign misalign     = mis_c && !rst;
  assign wb_we        = we_c && !rst;
  assign wb_reg_waddr = mem_reg_waddr;
  assign wb_reg_wdata = wdata_c;

endmodule

// File: tb/tb_mem_stage.sv
// tb/tb_mem_stage.sv - directed self-checking bench for mem_stage
module tb_mem_stage;
  import mem_stage_pkg::*;

  logic        clk, rst;
  logic [4:0]  mem_reg_waddr;
  logic        mem_we;
  logic [31:0] mem_reg_wdata, mem_mem_addr, mem_rt_data;
  logic [7:0]  mem_aluop;
  logic        hold;
  logic        dmem_req, dmem_wr, dmem_ack;
  logic [31:0] dmem_addr, dmem_wdata, dmem_rdata;
  logic [3:0]  dmem_be;
  logic [4:0]  wb_reg_waddr;
  logic        wb_we;
  logic [31:0] wb_reg_wdata;
  logic        stall_req, misalign;

  int n_assert = 0;
  int n_fail   = 0;

  mem_stage #(.ADDR_W(32), .DATA_W(32)) dut (
    .clk(clk), .rst(rst),
    .mem_reg_waddr(mem_reg_waddr), .mem_we(mem_we), .mem_reg_wdata(mem_reg_wdata),
    .mem_mem_addr(mem_mem_addr), .mem_aluop(mem_aluop), .mem_rt_data(mem_rt_data),
    .hold(hold),
    .dmem_req(dmem_req), .dmem_wr(dmem_wr), .dmem_addr(dmem_addr), .dmem_be(dmem_be),
    .dmem_wdata(dmem_wdata), .dmem_ack(dmem_ack), .dmem_rdata(dmem_rdata),
    .wb_reg_waddr(wb_reg_waddr), .wb_we(wb_we), .wb_reg_wdata(wb_reg_wdata),
    .stall_req(stall_req), .misalign(misalign)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Issue one aligned access, ack on the last of (waits+1) request cycles, then check DONE.
  task automatic do_access(input string tag, input logic [7:0] op, input logic [31:0] addr,
                           input logic [31:0] rt, input logic [31:0] rdata, input int waits,
                           input logic [3:0] exp_be, input logic [31:0] exp_dw,
                           input logic exp_wr, input logic [31:0] exp_wb, input logic exp_we);
    int stall_cnt;
    stall_cnt     = 0;
    mem_aluop     = op;
    mem_mem_addr  = addr;
    mem_rt_data   = rt;
    mem_we        = 1'b1;
    mem_reg_waddr = 5'd7;
    mem_reg_wdata = 32'h5555_AAAA;
    for (int c = 0; c <= waits; c++) begin
      dmem_ack   = (c == waits);
      dmem_rdata = (c == waits) ? rdata : 32'h0BAD_0BAD;
      #1;
      if (stall_req) stall_cnt++;
      chk({tag, ".req"},   {31'b0, dmem_req}, 32'd1);
      chk({tag, ".addr"},  dmem_addr, {addr[31:2], 2'b00});
      chk({tag, ".be"},    {28'b0, dmem_be}, {28'b0, exp_be});
      chk({tag, ".wr"},    {31'b0, dmem_wr}, {31'b0, exp_wr});
      chk({tag, ".bubble"}, {31'b0, wb_we}, 32'd0);
      if (exp_wr) chk({tag, ".wdata"}, dmem_wdata, exp_dw);
      tick();
    end
    dmem_ack   = 1'b0;
    dmem_rdata = 32'hFFFF_0000;
    #1;
    chk({tag, ".stall_cycles"}, 32'(stall_cnt), 32'(waits + 1));
    chk({tag, ".done_stall"}, {31'b0, stall_req}, 32'd0);
    chk({tag, ".done_req"},   {31'b0, dmem_req}, 32'd0);
    chk({tag, ".done_we"},    {31'b0, wb_we}, {31'b0, exp_we});
    chk({tag, ".done_waddr"}, {27'b0, wb_reg_waddr}, 32'd7);
    if (!exp_wr) chk({tag, ".done_wdata"}, wb_reg_wdata, exp_wb);
  endtask

  initial begin
    rst = 1'b1; hold = 1'b0;
    mem_aluop = EXE_LW_OP; mem_mem_addr = 32'h100; mem_rt_data = 32'h0;
    mem_we = 1'b1; mem_reg_waddr = 5'd1; mem_reg_wdata = 32'h0;
    dmem_ack = 1'b1; dmem_rdata = 32'h1234_5678;
    tick(); tick();
    chk("rst.req",   {31'b0, dmem_req}, 32'd0);
    chk("rst.stall", {31'b0, stall_req}, 32'd0);
    chk("rst.we",    {31'b0, wb_we}, 32'd0);
    chk("rst.mis",   {31'b0, misalign}, 32'd0);
    chk("rst.state", {30'b0, dut.state}, {30'b0, ST_IDLE});
    chk("rst.rdata_q", dut.rdata_q, 32'h0);
    rst = 1'b0; mem_aluop = EXE_NOP_OP; dmem_ack = 1'b0;
    tick();

    do_access("lw", EXE_LW_OP, 32'h100, 32'h0, 32'hDEAD_BEEF, 0, 4'b1111, 32'h0, 1'b0, 32'hDEAD_BEEF, 1'b1);
    tick();
    do_access("lb", EXE_LB_OP, 32'h103, 32'h0, 32'h8011_2233, 3, 4'b1000, 32'h0, 1'b0, 32'hFFFF_FF80, 1'b1);
    tick();
    do_access("lbu", EXE_LBU_OP, 32'h103, 32'h0, 32'h8011_2233, 3, 4'b1000, 32'h0, 1'b0, 32'h0000_0080, 1'b1);
    tick();
    do_access("lhu", EXE_LHU_OP, 32'h40, 32'h0, 32'h1234_F00D, 1, 4'b0011, 32'h0, 1'b0, 32'h0000_F00D, 1'b1);
    tick();
    do_access("sh", EXE_SH_OP, 32'h22, 32'h1234_ABCD, 32'h0, 0, 4'b1100, 32'hABCD_ABCD, 1'b1, 32'h0, 1'b0);
    tick();
    do_access("sb", EXE_SB_OP, 32'h31, 32'h0000_00A5, 32'h0, 2, 4'b0010, 32'hA5A5_A5A5, 1'b1, 32'h0, 1'b0);
    tick();

    mem_aluop = EXE_LW_OP; mem_mem_addr = 32'h102; mem_we = 1'b1; dmem_ack = 1'b0;
    #1;
    chk("mis.flag",  {31'b0, misalign}, 32'd1);
    chk("mis.req",   {31'b0, dmem_req}, 32'd0);
    chk("mis.stall", {31'b0, stall_req}, 32'd0);
    chk("mis.we",    {31'b0, wb_we}, 32'd0);
    tick();
    mem_aluop = EXE_SH_OP; mem_mem_addr = 32'h23;
    #1;
    chk("mis_sh.flag", {31'b0, misalign}, 32'd1);
    chk("mis_sh.req",  {31'b0, dmem_req}, 32'd0);
    tick();

    mem_aluop = EXE_ADD_OP; mem_reg_wdata = 32'h5; mem_reg_waddr = 5'd3; mem_we = 1'b1;
    #1;
    chk("add.waddr", {27'b0, wb_reg_waddr}, 32'd3);
    chk("add.wdata", wb_reg_wdata, 32'h5);
    chk("add.we",    {31'b0, wb_we}, 32'd1);
    chk("add.req",   {31'b0, dmem_req}, 32'd0);
    chk("add.stall", {31'b0, stall_req}, 32'd0);
    chk("add.mis",   {31'b0, misalign}, 32'd0);
    tick();

    mem_aluop = EXE_LW_OP; mem_mem_addr = 32'h200; dmem_ack = 1'b0;
    tick();
    chk("rstw.in_wait", {30'b0, dut.state}, {30'b0, ST_WAIT});
    chk("rstw.req_wait", {31'b0, dmem_req}, 32'd1);
    rst = 1'b1;
    #1;
    chk("rstw.req_forced", {31'b0, dmem_req}, 32'd0);
    tick();
    rst = 1'b0; mem_aluop = EXE_NOP_OP;
    #1;
    chk("rstw.req",   {31'b0, dmem_req}, 32'd0);
    chk("rstw.state", {30'b0, dut.state}, {30'b0, ST_IDLE});
    tick();

    do_access("lh", EXE_LH_OP, 32'h2, 32'h0, 32'h8001_0000, 0, 4'b1100, 32'h0, 1'b0, 32'hFFFF_8001, 1'b1);
    hold = 1'b1;
    for (int k = 0; k < 2; k++) begin
      dmem_ack = 1'b1; dmem_rdata = 32'h7777_7777;
      tick();
      dmem_ack = 1'b0;
      #1;
      chk("hold.state", {30'b0, dut.state}, {30'b0, ST_DONE});
      chk("hold.wdata", wb_reg_wdata, 32'hFFFF_8001);
      chk("hold.we",    {31'b0, wb_we}, 32'd1);
      chk("hold.req",   {31'b0, dmem_req}, 32'd0);
    end
    hold = 1'b0;
    tick();
    mem_aluop = EXE_NOP_OP;
    #1;
    chk("hold.release", {30'b0, dut.state}, {30'b0, ST_IDLE});

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
